mac_vec_engine: RTL and testbench
=================================

# mac_vec_engine

Parametrised multi-lane multiply-accumulate engine for the HWPE MAC accelerator. It is the successor to the single-lane 32-bit MAC datapath. It sits between the streamer (input streams a/b/c, output stream d) and the controller (ctrl/flags), and processes N_LANES independent signed lanes per beat. It adds two features the single-lane engine lacks: a configurable rounding right-shift with saturation, and a per-job bias taken from stream c.

## Interface
- N_LANES, 4: parallel lanes per beat.
- DW, 16: signed operand/result width per lane.
- LEN_W, 16: width of the job length counter; maximum job length is 2^LEN_W-1 beats.
- clk_i  in  1  the only clock; every register is on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- a_valid_i / a_ready_o / a_data_i  in/out/in  1/1/N_LANES*DW  operand A stream; lane k is bits [k*DW +: DW].
- b_valid_i / b_ready_o / b_data_i  in/out/in  1/1/N_LANES*DW  operand B stream, same lane layout.
- c_valid_i / c_ready_o / c_data_i  in/out/in  1/1/N_LANES*DW  bias stream, one beat per accumulate job.
- d_valid_o / d_ready_i / d_data_o  out/in/out  1/1/N_LANES*DW  result stream.
- ctrl_i  in  ctrl_mac_vec_t  control fields: start (1-cycle pulse), clear (1-cycle pulse), simple_mul (1 bit), len (LEN_W), shift (clog2(2*DW) bits).
- flags_o  out  flags_mac_vec_t  status fields: busy, done (1-cycle pulse), cnt (LEN_W, beats consumed in the current job).

## Operation
- Job parameters are captured at start and held for the whole job.
- FSM states:
  - IDLE: start → BIAS if simple_mul=0, otherwise RUN.
  - BIAS: consume one c beat into the per-lane accumulators (sign-extended, then left-shifted by shift), then go to RUN.
  - RUN: consume a/b beats until cnt==len, then go to DRAIN.
  - DRAIN: wait until the last d beat is accepted, pulse done, return to IDLE.
- len=0 in either mode: go straight to DRAIN. No a/b/c beats are consumed and no d beat is produced; done pulses 1 cycle after start.
- a and b fire jointly: a fire occurs only when a_valid_i & b_valid_i & a_ready_o. a_ready_o == b_ready_o, asserted in RUN when stage 1 can advance. No combinational path from valid to ready.
- c_ready_o is asserted only in BIAS.
- Per lane, stage 1 registers p = a*b (signed, 2*DW bits).
- Stage 2, simple_mul=1: result = sat_DW(round(p >>> shift)); one d beat per a/b beat.
- Stage 2, simple_mul=0: acc += p, with acc width 2*DW+LEN_W. After the len-th product, result = sat_DW(round(acc >>> shift)); one d beat per job.
- Rounding: add 2^(shift-1) before the shift; no rounding when shift=0.
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1].
- Once d_valid_o is high, d_data_o stays stable until d_ready_i. Backpressure on d stalls stage 2 and then stage 1; no beat is lost or duplicated.
- start while busy=1 is ignored.
- clear at any time, and rst_i, have the same effect: next cycle state=IDLE, pipeline valids=0, accumulators=0, cnt=0. An in-flight d beat is dropped and done is not pulsed.
- clear and start in the same cycle: clear wins.

## Timing
- Reset values: a_ready_o=b_ready_o=c_ready_o=0, d_valid_o=0, d_data_o=0, busy=0, done=0, cnt=0.
- busy goes high the cycle after an accepted start and goes low in the cycle done pulses.
- Simple mode: a/b fire at cycle t → d_valid_o at t+2 when unstalled. Throughput is 1 beat/cycle.
- Accumulate mode: last a/b fire at t → d_valid_o at t+2. done pulses the cycle after the d handshake.
- cnt increments in the cycle following each a/b fire.
- Bias: c fire at t → first RUN cycle is t+1.

## Structure
- mac_vec_package holds ctrl_mac_vec_t, flags_mac_vec_t, the FSM state enum, and default parameter constants.
- Sub-module mac_vec_lane: per-lane multiplier, accumulator, round/saturate and the stage registers. It is instantiated N_LANES times.
- The top level holds the FSM, counter and stream handshakes only.

## Test plan
- Simple mode, DW=16, shift=0, a=3, b=-4 in all lanes, d_ready_i=1: d=-12 in every lane, 2 cycles after the fire.
- Accumulate, len=4, c=10, a=b=2 for all beats, shift=1: exactly one d beat, value (10*2+16)>>1 → 18 with rounding; done pulses once.
- Saturation: simple mode, a=b=0x7FFF, shift=0 → d=0x7FFF. a=0x8000, b=0x7FFF → d=0x8000.
- Backpressure: d_ready_i toggling randomly over 100 simple-mode beats → output sequence identical to the golden model, no drops or duplicates, a_ready_o low while stalled.
- clear pulsed mid-job (cnt=2 of len=8) → next cycle busy=0, d_valid_o=0, no done. A following job, len=1, a=b=5 → d=25.
- len=0 start → done pulses 1 cycle later; no beat is consumed on a/b/c and no d beat is produced.

Source files
------------

// File: rtl/mac_vec_package.sv
// Shared types and default sizes for the multi-lane MAC engine.
// Imported by the engine top level and its lane datapath.
package mac_vec_package;

  localparam int N_LANES_D = 4;
  localparam int DW_D      = 16;
  localparam int LEN_W_D   = 16;
  localparam int SH_W_D    = $clog2(2 * DW_D);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIAS  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic               start;
    logic               clear;
    logic               simple_mul;
    logic [LEN_W_D-1:0] len;
    logic [SH_W_D-1:0]  shift;
  } ctrl_mac_vec_t;

  typedef struct packed {
    logic               busy;
    logic               done;
    logic [LEN_W_D-1:0] cnt;
  } flags_mac_vec_t;

endpackage

// File: rtl/mac_vec_lane.sv
// One signed MAC lane: product register, wide accumulator,
// rounding right-shift with saturation, and the output register.
module mac_vec_lane
  import mac_vec_package::*;
#(
  parameter int DW    = DW_D,
  parameter int LEN_W = LEN_W_D,
  parameter int SW    = $clog2(2 * DW)
) (
  input  logic          clk_i,
  input  logic          i_flush,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_c,
  input  logic [SW-1:0] i_shift,
  input  logic          i_s1_en,
  input  logic          i_bias_en,
  input  logic          i_acc_en,
  input  logic          i_sel_acc,
  input  logic          i_d_en,
  output logic [DW-1:0] o_d
);

  localparam int PW = 2 * DW;
  localparam int AW = PW + LEN_W;

  logic [PW-1:0] r_p;
  logic [AW-1:0] r_acc;
  logic [DW-1:0] r_d;

  logic [PW-1:0]        w_a_ext;
  logic [PW-1:0]        w_b_ext;
  logic [AW-1:0]        w_p_ext;
  logic [AW-1:0]        w_sum;
  logic [AW-1:0]        w_bias;
  logic [AW-1:0]        w_src;
  logic [AW:0]          w_half;
  logic signed [AW:0]   w_rnd;
  logic signed [AW:0]   w_sh;
  logic                 w_fits;
  logic [DW-1:0]        w_res;

  assign w_a_ext = {{DW{i_a[DW-1]}}, i_a};
  assign w_b_ext = {{DW{i_b[DW-1]}}, i_b};
  assign w_p_ext = {{LEN_W{r_p[PW-1]}}, r_p};
  assign w_sum   = r_acc + w_p_ext;
  assign w_bias  = {{(AW-DW){i_c[DW-1]}}, i_c} << i_shift;
  assign w_src   = i_sel_acc ? w_sum : w_p_ext;

  // One extra bit keeps the rounding add from wrapping.
  assign w_half = (i_shift == '0) ? '0
                : ((AW+1)'(1) << (i_shift - SW'(1)));
  assign w_rnd  = {w_src[AW-1], w_src} + w_half;
  assign w_sh   = w_rnd >>> i_shift;

  assign w_fits = (&w_sh[AW:DW-1]) | ~(|w_sh[AW:DW-1]);
  assign w_res  = w_fits   ? w_sh[DW-1:0]
                : w_sh[AW] ? {1'b1, {(DW-1){1'b0}}}
                :            {1'b0, {(DW-1){1'b1}}};

  always_ff @(posedge clk_i) begin
    if (i_flush) begin
      r_p   <= '0;
      r_acc <= '0;
      r_d   <= '0;
    end else begin
      if (i_s1_en)
        r_p <= w_a_ext * w_b_ext;
      if (i_bias_en)
        r_acc <= w_bias;
      else if (i_acc_en)
        r_acc <= w_sum;
      if (i_d_en)
        r_d <= w_res;
    end
  end

  assign o_d = r_d;

endmodule

// File: rtl/mac_vec_engine.sv
// Multi-lane MAC engine: job FSM, beat counter and stream
// handshakes around N_LANES copies of the lane datapath.
module mac_vec_engine
  import mac_vec_package::*;
#(
  parameter int N_LANES = N_LANES_D,
  parameter int DW      = DW_D,
  parameter int LEN_W   = LEN_W_D
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [N_LANES*DW-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [N_LANES*DW-1:0] b_data_i,
  input  logic                  c_valid_i,
  output logic                  c_ready_o,
  input  logic [N_LANES*DW-1:0] c_data_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [N_LANES*DW-1:0] d_data_o,
  input  ctrl_mac_vec_t         ctrl_i,
  output flags_mac_vec_t        flags_o
);

  localparam int SW = $clog2(2 * DW);

  state_e           r_state;
  logic             r_simple;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [SW-1:0]    r_shift;
  logic             r_s1_valid;
  logic             r_s1_last;
  logic             r_d_valid;
  logic             r_done;

  logic w_flush;
  logic w_d_free;
  logic w_s2_adv;
  logic w_d_load;
  logic w_acc_en;
  logic w_s1_free;
  logic w_ab_ready;
  logic w_ab_fire;
  logic w_c_fire;
  logic w_drain_ok;

  assign w_flush    = rst_i | ctrl_i.clear;
  assign w_d_free   = ~r_d_valid | d_ready_i;
  // Non-final accumulate products never need the output slot.
  assign w_s2_adv   = r_s1_valid
                    & (w_d_free | (~r_simple & ~r_s1_last));
  assign w_d_load   = w_s2_adv & (r_simple | r_s1_last);
  assign w_acc_en   = w_s2_adv & ~r_simple;
  assign w_s1_free  = ~r_s1_valid | w_s2_adv;
  assign w_ab_ready = (r_state == ST_RUN)
                    & (r_cnt != r_len) & w_s1_free;
  assign w_ab_fire  = a_valid_i & b_valid_i & w_ab_ready;
  assign w_c_fire   = c_valid_i & (r_state == ST_BIAS);
  assign w_drain_ok = ~r_s1_valid & w_d_free;

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_state  <= ST_IDLE;
      r_simple <= 1'b0;
      r_len    <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ab_fire)
        r_cnt <= r_cnt + LEN_W'(1);
      unique case (r_state)
        ST_IDLE: begin
          if (ctrl_i.start) begin
            r_simple <= ctrl_i.simple_mul;
            r_len    <= ctrl_i.len;
            r_shift  <= ctrl_i.shift;
            r_cnt    <= '0;
            // An empty job has nothing to drain.
            if (ctrl_i.len == '0)
              r_done <= 1'b1;
            else
              r_state <= ctrl_i.simple_mul ? ST_RUN : ST_BIAS;
          end
        end
        ST_BIAS: begin
          if (w_c_fire)
            r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cnt == r_len)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drain_ok) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      if (w_ab_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_last  <= (r_cnt + LEN_W'(1)) == r_len;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_d_load)
        r_d_valid <= 1'b1;
      else if (d_ready_i)
        r_d_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    mac_vec_lane #(
      .DW    (DW),
      .LEN_W (LEN_W),
      .SW    (SW)
    ) u_lane (
      .clk_i     (clk_i),
      .i_flush   (w_flush),
      .i_a       (a_data_i[k*DW +: DW]),
      .i_b       (b_data_i[k*DW +: DW]),
      .i_c       (c_data_i[k*DW +: DW]),
      .i_shift   (r_shift),
      .i_s1_en   (w_ab_fire),
      .i_bias_en (w_c_fire),
      .i_acc_en  (w_acc_en),
      .i_sel_acc (~r_simple),
      .i_d_en    (w_d_load),
      .o_d       (d_data_o[k*DW +: DW])
    );
  end

  assign a_ready_o = w_ab_ready;
  assign b_ready_o = w_ab_ready;
  assign c_ready_o = (r_state == ST_BIAS);
  assign d_valid_o = r_d_valid;

  assign flags_o = '{busy: (r_state != ST_IDLE),
                     done: r_done,
                     cnt:  r_cnt};

endmodule

// File: tb/tb_mac_vec_engine.sv
// Bench for mac_vec_engine: random streams checked against a
// per-lane arithmetic model of multiply, accumulate, round, saturate.
module tb_mac_vec_engine;
  import mac_vec_package::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic          c_valid, c_ready, d_valid, d_ready;
  logic [VW-1:0] a_data, b_data, c_data, d_data;
  ctrl_mac_vec_t  ctrl;
  flags_mac_vec_t flags;

  mac_vec_engine #(.N_LANES(N), .DW(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_data_o(d_data),
    .ctrl_i(ctrl), .flags_o(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  logic [VW-1:0] dq[$];
  int            dqc[$];
  logic [VW-1:0] va[$];
  logic [VW-1:0] vb[$];
  int fires = 0, cfires = 0, dones = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (a_valid & b_valid & a_ready) fires++;
    if (c_valid & c_ready) cfires++;
    if (d_valid & d_ready) begin
      dq.push_back(d_data);
      dqc.push_back(cyc);
    end
    if (flags.done) begin
      dones++;
      done_cyc = cyc;
    end
  end

  function automatic longint lane_of(logic [VW-1:0] v, int k);
    logic signed [DW-1:0] x;
    x = v[k*DW +: DW];
    return longint'(x);
  endfunction

  function automatic longint rnd_sat(longint v, int sh);
    longint r, mx;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    r = v;
    if (sh > 0) r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_simple(logic [VW-1:0] a,
                                               logic [VW-1:0] b, int sh);
    logic [VW-1:0] o;
    o = '0;
    for (int k = 0; k < N; k++)
      o[k*DW +: DW] = DW'(rnd_sat(lane_of(a, k) * lane_of(b, k), sh));
    return o;
  endfunction

  function automatic logic [VW-1:0] exp_accum(logic [VW-1:0] c, int sh);
    logic [VW-1:0] o;
    longint s;
    o = '0;
    for (int k = 0; k < N; k++) begin
      s = lane_of(c, k) <<< sh;
      for (int i = 0; i < va.size(); i++)
        s += lane_of(va[i], k) * lane_of(vb[i], k);
      o[k*DW +: DW] = DW'(rnd_sat(s, sh));
    end
    return o;
  endfunction

  task automatic do_start(input bit sm, input int len, input int sh);
    ctrl.start = 1'b1;
    ctrl.simple_mul = sm;
    ctrl.len = LW'(len);
    ctrl.shift = SH_W_D'(sh);
    @(posedge clk); #1;
    ctrl.start = 1'b0;
  endtask

  task automatic send_c(input logic [VW-1:0] c, output bit to);
    int k;
    bit f;
    k = 0;
    f = 1'b0;
    c_valid = 1'b1;
    c_data = c;
    while (!f && k < 20) begin
      @(negedge clk);
      f = c_ready;
      @(posedge clk); #1;
      k++;
    end
    c_valid = 1'b0;
    to = !f;
  endtask

  // Streams va/vb pairs with random gaps until the job reports done.
  task automatic drive_ab(input int vpct, input int rpct,
                          input int budget, output bit to);
    int i, k, d0;
    bit f;
    i = 0;
    k = 0;
    d0 = dones;
    while ((i < va.size() || dones == d0) && k < budget) begin
      a_valid = (i < va.size()) && ($urandom_range(99) < vpct);
      b_valid = (i < va.size()) && ($urandom_range(99) < vpct);
      a_data = (i < va.size()) ? va[i] : VW'({$urandom, $urandom});
      b_data = (i < vb.size()) ? vb[i] : VW'({$urandom, $urandom});
      d_ready = $urandom_range(99) < rpct;
      @(negedge clk);
      f = a_valid & b_valid & a_ready;
      @(posedge clk); #1;
      if (f) i++;
      k++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    d_ready = 1'b1;
    to = (k >= budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
    total++; if (c_ready !== 1'b0) begin bad++; $display("FAIL rst_c_ready got=%b exp=0", c_ready); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
    total++; if (d_data !== '0) begin bad++; $display("FAIL rst_d_data got=%h exp=0", d_data); end
    total++; if (flags.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", flags.busy); end
    total++; if (flags.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", flags.done); end
    total++; if (flags.cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", flags.cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_simple_latency();
    int fc, dc, k, d0;
    logic [VW-1:0] dg, a, b;
    a = {N{16'h0003}};
    b = {N{16'hFFFC}};
    d0 = dones;
    d_ready = 1'b1;
    do_start(1'b1, 1, 0);
    @(negedge clk);
    total++; if (flags.busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b exp=1", flags.busy); end
    @(posedge clk); #1;
    a_valid = 1'b1; b_valid = 1'b1; a_data = a; b_data = b;
    fc = -1; k = 0;
    while (fc < 0 && k < 10) begin
      @(negedge clk);
      if (a_valid & b_valid & a_ready) fc = cyc;
      @(posedge clk); #1;
      k++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    dc = -1; k = 0; dg = '0;
    while (dc < 0 && k < 10) begin
      @(negedge clk);
      if (d_valid) begin dc = cyc; dg = d_data; end
      @(posedge clk); #1;
      k++;
    end
    total++; if (fc < 0 || dc !== fc + 2) begin bad++; $display("FAIL lat_cycles got=%0d exp=%0d", dc, fc + 2); end
    total++; if (dg !== exp_simple(a, b, 0)) begin bad++; $display("FAIL lat_data got=%h exp=%h", dg, exp_simple(a, b, 0)); end
    repeat (3) @(posedge clk); #1;
    total++; if (dones !== d0 + 1) begin bad++; $display("FAIL lat_done got=%0d exp=%0d", dones - d0, 1); end
    total++; if (flags.cnt !== 16'd1) begin bad++; $display("FAIL lat_cnt got=%0d exp=1", flags.cnt); end
  endtask

  task automatic test_accum_basic();
    bit to;
    int d0, c0;
    logic [VW-1:0] c;
    c = {N{16'd10}};
    dq.delete(); dqc.delete(); va.delete(); vb.delete();
    repeat (4) begin va.push_back({N{16'd2}}); vb.push_back({N{16'd2}}); end
    d0 = dones; c0 = cfires;
    do_start(1'b0, 4, 1);
    send_c(c, to);
    total++; if (to) begin bad++; $display("FAIL acc_c_timeout got=1 exp=0"); end
    drive_ab(100, 100, 60, to);
    total++; if (to) begin bad++; $display("FAIL acc_timeout got=1 exp=0"); end
    total++; if (dq.size() != 1 || dq[0] !== exp_accum(c, 1)) begin
      bad++; $display("FAIL acc_data beats=%0d got=%h exp=%h", dq.size(), (dq.size() > 0) ? dq[0] : '0, exp_accum(c, 1)); end
    total++; if (dones !== d0 + 1) begin bad++; $display("FAIL acc_done got=%0d exp=1", dones - d0); end
    total++; if (dqc.size() != 1 || done_cyc !== dqc[0] + 1) begin bad++; $display("FAIL acc_done_cyc got=%0d exp=d+1", done_cyc); end
    total++; if (cfires !== c0 + 1) begin bad++; $display("FAIL acc_cbeats got=%0d exp=1", cfires - c0); end
  endtask

  task automatic test_saturation();
    bit to;
    dq.delete(); va.delete(); vb.delete();
    va.push_back({N{16'h7FFF}}); vb.push_back({N{16'h7FFF}});
    va.push_back({N{16'h8000}}); vb.push_back({N{16'h7FFF}});
    va.push_back({N{16'h8000}}); vb.push_back({N{16'h8000}});
    do_start(1'b1, 3, 0);
    drive_ab(100, 100, 60, to);
    total++; if (to || dq.size() != 3) begin bad++; $display("FAIL sat_beats got=%0d exp=3", dq.size()); end
    for (int i = 0; i < 3 && i < dq.size(); i++) begin
      total++;
      if (dq[i] !== exp_simple(va[i], vb[i], 0)) begin
        bad++; $display("FAIL sat_data[%0d] got=%h exp=%h", i, dq[i], exp_simple(va[i], vb[i], 0)); end
    end
  endtask

  task automatic test_accum_random();
    bit to;
    int len, sh, d0;
    logic [VW-1:0] c;
    for (int r = 0; r < 4; r++) begin
      dq.delete(); va.delete(); vb.delete();
      len = $urandom_range(6, 1);
      sh = $urandom_range(20, 0);
      c = VW'({$urandom, $urandom});
      for (int i = 0; i < len; i++) begin
        va.push_back(VW'({$urandom, $urandom}));
        vb.push_back(VW'({$urandom, $urandom}));
      end
      d0 = dones;
      do_start(1'b0, len, sh);
      send_c(c, to);
      drive_ab(70, 60, 200, to);
      total++; if (to) begin bad++; $display("FAIL rnd_timeout run=%0d", r); end
      total++; if (dq.size() != 1 || dq[0] !== exp_accum(c, sh)) begin
        bad++; $display("FAIL rnd_data run=%0d beats=%0d got=%h exp=%h", r, dq.size(), (dq.size() > 0) ? dq[0] : '0, exp_accum(c, sh)); end
      total++; if (dones !== d0 + 1) begin bad++; $display("FAIL rnd_done run=%0d got=%0d exp=1", r, dones - d0); end
    end
  endtask

  task automatic test_backpressure();
    int i, k, d0, sh;
    bit f, pf;
    dq.delete(); va.delete(); vb.delete();
    for (int j = 0; j < 100; j++) begin
      va.push_back(VW'({$urandom, $urandom}));
      vb.push_back(VW'({$urandom, $urandom}));
    end
    sh = $urandom_range(15, 0);
    d0 = dones;
    do_start(1'b1, 100, sh);
    i = 0; k = 0; pf = 1'b0;
    while ((i < 100 || dones == d0) && k < 2000) begin
      a_valid = (i < 100) && ($urandom_range(99) < 80);
      b_valid = (i < 100) && ($urandom_range(99) < 90);
      a_data = (i < 100) ? va[i] : '0;
      b_data = (i < 100) ? vb[i] : '0;
      d_ready = $urandom_range(99) < 50;
      @(negedge clk);
      f = a_valid & b_valid & a_ready;
      if (pf && d_valid && !d_ready) begin
        total++;
        if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", cyc, a_ready); end
      end
      pf = f;
      @(posedge clk); #1;
      if (f) i++;
      k++;
    end
    a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b1;
    total++; if (k >= 2000) begin bad++; $display("FAIL bp_timeout got=%0d beats", i); end
    total++; if (dq.size() != 100) begin bad++; $display("FAIL bp_count got=%0d exp=100", dq.size()); end
    for (int j = 0; j < 100 && j < dq.size(); j++) begin
      total++;
      if (dq[j] !== exp_simple(va[j], vb[j], sh)) begin
        bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", j, dq[j], exp_simple(va[j], vb[j], sh)); end
    end
  endtask

  task automatic test_clear();
    bit to;
    int k, d0, f0;
    dq.delete();
    d0 = dones;
    d_ready = 1'b1;
    do_start(1'b0, 8, 0);
    send_c(VW'({$urandom, $urandom}), to);
    f0 = fires;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = VW'({$urandom, $urandom}); b_data = VW'({$urandom, $urandom});
    k = 0;
    while (fires < f0 + 2 && k < 20) begin
      @(negedge clk);
      @(posedge clk); #1;
      k++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    ctrl.clear = 1'b1;
    @(negedge clk);
    total++; if (flags.cnt !== 16'd2) begin bad++; $display("FAIL clr_cnt_before got=%0d exp=2", flags.cnt); end
    @(posedge clk); #1;
    ctrl.clear = 1'b0;
    @(negedge clk);
    total++; if (flags.busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", flags.busy); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL clr_d_valid got=%b exp=0", d_valid); end
    total++; if (flags.cnt !== '0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", flags.cnt); end
    repeat (6) @(posedge clk); #1;
    total++; if (dones !== d0 || dq.size() != 0) begin bad++; $display("FAIL clr_quiet dones=%0d beats=%0d exp=0", dones - d0, dq.size()); end
    va.delete(); vb.delete();
    va.push_back({N{16'd5}}); vb.push_back({N{16'd5}});
    do_start(1'b1, 1, 0);
    drive_ab(100, 100, 40, to);
    total++; if (to || dq.size() != 1 || dq[0] !== exp_simple(va[0], vb[0], 0)) begin
      bad++; $display("FAIL clr_next beats=%0d got=%h exp=%h", dq.size(), (dq.size() > 0) ? dq[0] : '0, exp_simple(va[0], vb[0], 0)); end
  endtask

  task automatic test_len0();
    int d0, f0, c0;
    for (int m = 0; m < 2; m++) begin
      dq.delete();
      d0 = dones; f0 = fires; c0 = cfires;
      a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_ready = 1'b1;
      do_start(m == 0, 0, 0);
      @(negedge clk);
      total++; if (flags.done !== 1'b1) begin bad++; $display("FAIL len0_done mode=%0d got=%b exp=1", m, flags.done); end
      repeat (5) @(posedge clk); #1;
      total++; if (dones !== d0 + 1) begin bad++; $display("FAIL len0_pulses mode=%0d got=%0d exp=1", m, dones - d0); end
      total++; if (fires !== f0 || cfires !== c0 || dq.size() != 0) begin
        bad++; $display("FAIL len0_beats mode=%0d ab=%0d c=%0d d=%0d exp=0", m, fires - f0, cfires - c0, dq.size()); end
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    end
  endtask

  task automatic test_start_busy();
    bit to;
    int d0;
    dq.delete(); va.delete(); vb.delete();
    for (int i = 0; i < 3; i++) begin
      va.push_back(VW'({$urandom, $urandom}));
      vb.push_back(VW'({$urandom, $urandom}));
    end
    d0 = dones;
    do_start(1'b1, 3, 0);
    do_start(1'b0, 1, 5);
    drive_ab(60, 70, 100, to);
    total++; if (to || dq.size() != 3 || dones !== d0 + 1) begin
      bad++; $display("FAIL busy_start beats=%0d dones=%0d exp=3,1", dq.size(), dones - d0); end
    for (int i = 0; i < 3 && i < dq.size(); i++) begin
      total++;
      if (dq[i] !== exp_simple(va[i], vb[i], 0)) begin
        bad++; $display("FAIL busy_data[%0d] got=%h exp=%h", i, dq[i], exp_simple(va[i], vb[i], 0)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b1;
    a_data = '0; b_data = '0; c_data = '0;
    ctrl = '0;
    test_reset();
    test_simple_latency();
    test_accum_basic();
    test_saturation();
    test_accum_random();
    test_backpressure();
    test_clear();
    test_len0();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
